ex_muldiv: RTL and testbench
============================

# ex_muldiv

Multi-cycle multiply/divide unit sitting in the EX stage. It consumes the ALU-select/ALU-op and operand outputs of the ID/EX pipeline register. For MULT, MULTU, DIV and DIVU it runs a 32-iteration shift-add multiply or a restoring divide, stalling the front of the pipeline while it works. When the operation finishes it writes the 64-bit result to HI/LO with a one-cycle write strobe.

## Interface
- No parameters. Widths come from the shared defines header.
- New defines in that header: `EX_HIGH_MULDIV` (alusel group), and the aluop codes `EX_MULDIV_MULT`, `EX_MULDIV_MULTU`, `EX_MULDIV_DIV`, `EX_MULDIV_DIVU`.
- Clock and reset:
  - clk  in  1  single clock; all state updates on posedge.
  - rst  in  1  asynchronous, active-low reset.
- Operation inputs:
  - ex_alusel  in  `EX_OP_HIGH_BUS`  operation group from ID/EX.
  - ex_aluop  in  `EX_OP_LOW_BUS`  operation within the group.
  - ex_srcLeft  in  `WORD_BUS`  dividend / multiplicand.
  - ex_srcRight  in  `WORD_BUS`  divisor / multiplier.
  - flush  in  1  synchronous cancel of the in-flight operation.
- Outputs:
  - stall  out  1  combinational; holds IF/ID and ID/EX while high.
  - busy  out  1  registered; high in the BUSY state.
  - hi  out  `WORD_BUS`  result high word (remainder for divide).
  - lo  out  `WORD_BUS`  result low word (quotient for divide).
  - hilo_we  out  1  registered; one-cycle HI/LO write strobe.

## Operation
- States: IDLE, BUSY, DONE. Reset (rst=0) forces the following immediately, regardless of clk:
  - state=IDLE, counter=0, hi=0, lo=0, hilo_we=0, busy=0.
- `start` = state==IDLE && ex_alusel==`EX_HIGH_MULDIV` && flush==0.
- IDLE:
  - On start, latch the operands and the signed flag (set for MULT/DIV).
  - Signed ops: take absolute values; record the result signs (product/quotient sign = XOR of operand signs; remainder sign = dividend sign).
  - Divide with divisor 0 goes to DONE with hi=ex_srcLeft and lo=32'hFFFF_FFFF. Every other start goes to BUSY with counter=0.
  - Unrecognised aluop in the MULDIV group is treated as no-op: no start, stall=0.
- BUSY, one iteration per cycle, counter 0..31, then DONE:
  - Multiply: 64-bit accumulator, add-and-shift on each multiplier bit, LSB first.
  - Divide: restoring; shift the remainder left by 1 and bring in the next dividend bit, MSB first; subtract the divisor if remainder >= divisor, and set the quotient bit.
- Entering DONE:
  - Apply sign correction (two's-complement negate where the recorded sign is 1).
  - Drive hi/lo and set hilo_we=1 for exactly the DONE cycle.
  - DONE always returns to IDLE on the next edge, and never starts a new operation even if the ID/EX inputs still show MULDIV.
- stall = (state==IDLE && start) || state==BUSY. stall is 0 in DONE, so ID/EX advances at the end of DONE.
- flush=1 in any state:
  - next state=IDLE, hilo_we=0 on the next cycle, hi/lo keep their previous values; stall=0 that cycle.
  - flush beats start when both are asserted together.
- Arithmetic is 32-bit two's complement; absolute value uses unsigned wrap. Consequences:
  - 0x8000_0000 / 0xFFFF_FFFF (signed) gives lo=0x8000_0000, hi=0.
  - 0x8000_0000 * 0x8000_0000 (signed) gives hi=0x4000_0000, lo=0.
- hi/lo hold their values between operations; only DONE updates them.

## Timing
- Normal op, with cycle 0 being the cycle the op is present in EX in IDLE:
  - stall=1 in cycles 0..32 (IDLE plus 32 BUSY).
  - DONE in cycle 33: hilo_we=1, hi/lo valid, stall=0.
  - Total: 34 cycles in EX, 33 stall cycles.
- Divide by zero: stall=1 in cycle 0, DONE in cycle 1 (hilo_we=1).
- Back-to-back MULDIV ops: the second op is seen in IDLE in cycle 34 and starts there. There is no lost or duplicated start.
- Reset asserted mid-BUSY: outputs go to their reset values asynchronously. After release the unit sits in IDLE and re-examines its inputs.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF:
  - stall high 33 cycles.
  - Cycle 33: hilo_we=1, hi=0xFFFF_FFFE, lo=0x0000_0001.
- MULT 0xFFFF_FFFE (-2) × 3 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFFA, with one hilo_we pulse.
- Signed divides:
  - DIV 0xFFFF_FFF9 (-7) / 2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
  - DIV 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
- DIVU 100 / 0:
  - stall=1 for one cycle only.
  - Next cycle: hilo_we=1, hi=100, lo=0xFFFF_FFFF.
- flush in BUSY cycle 10:
  - Next cycle state IDLE, no hilo_we pulse; hi/lo unchanged from the prior result.
  - Then MULTU 3×5 completes with lo=15.
- rst driven low in BUSY cycle 5, asynchronously between edges -> hi=lo=0, hilo_we=0, stall=0 immediately. After release, MULTU 2×2 gives lo=4 at cycle 33.

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative 32x32 multiply / restoring divide unit for the EX stage.
// Runs one add-and-shift or subtract-and-shift step per cycle, stalls the front
// of the pipeline while busy, and strobes a 64-bit HI/LO result when done.

`ifndef EX_MULDIV_DEFINES_SV
`define EX_MULDIV_DEFINES_SV
`define WORD_BUS        31:0
`define EX_OP_HIGH_BUS  2:0
`define EX_OP_LOW_BUS   7:0
`define EX_HIGH_MULDIV  3'b110
`define EX_MULDIV_MULT  8'h18
`define EX_MULDIV_MULTU 8'h19
`define EX_MULDIV_DIV   8'h1A
`define EX_MULDIV_DIVU  8'h1B
`endif

module ex_muldiv (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [`EX_OP_HIGH_BUS] ex_alusel,
    input  logic [`EX_OP_LOW_BUS]  ex_aluop,
    input  logic [`WORD_BUS]       ex_srcLeft,
    input  logic [`WORD_BUS]       ex_srcRight,
    input  logic                   flush,
    output logic                   stall,
    output logic                   busy,
    output logic [`WORD_BUS]       hi,
    output logic [`WORD_BUS]       lo,
    output logic                   hilo_we
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Control state (asynchronously reset)
    state_t      state_q, state_d;
    logic [4:0]  counter_q, counter_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        hilo_we_q, hilo_we_d;
    logic        busy_q, busy_d;

    // Datapath state (only meaningful while an operation is in flight)
    // acc: multiply = {partial high, remaining multiplier / product low}
    //      divide   = {partial remainder, remaining dividend / quotient}
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;      // multiplicand or divisor magnitude
    logic        is_div_q, is_div_d;
    logic        neg_lo_q, neg_lo_d;  // product / quotient sign
    logic        neg_hi_q, neg_hi_d;  // remainder sign

    // Decode and operand conditioning
    logic        op_valid, op_signed, op_div, start;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;

    // Iteration step and final sign correction
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift, div_diff;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] div_next;
    logic [63:0] step_next;
    logic [63:0] mul_res;
    logic [31:0] fin_hi, fin_lo;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    // Decode the aluop within the MULDIV group; unknown codes are ignored
    always_comb begin
        op_valid  = 1'b0;
        op_signed = 1'b0;
        op_div    = 1'b0;
        case (ex_aluop)
            `EX_MULDIV_MULT:  begin op_valid = 1'b1; op_signed = 1'b1; end
            `EX_MULDIV_MULTU: begin op_valid = 1'b1; end
            `EX_MULDIV_DIV:   begin op_valid = 1'b1; op_signed = 1'b1; op_div = 1'b1; end
            `EX_MULDIV_DIVU:  begin op_valid = 1'b1; op_div = 1'b1; end
            default:          begin op_valid = 1'b0; end
        endcase
    end

    // A new operation only begins from IDLE; flush and reset suppress it
    assign start = rst && (state_q == S_IDLE) && (ex_alusel == `EX_HIGH_MULDIV)
                   && op_valid && !flush;

    // Magnitudes use wrapping negation, so 0x8000_0000 stays 0x8000_0000
    assign a_neg = op_signed & ex_srcLeft[31];
    assign b_neg = op_signed & ex_srcRight[31];
    assign a_mag = a_neg ? neg32(ex_srcLeft)  : ex_srcLeft;
    assign b_mag = b_neg ? neg32(ex_srcRight) : ex_srcRight;

    // One multiply step and one restoring-divide step from the current accumulator
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
        mul_next  = {mul_sum, acc_q[31:1]};

        div_shift = {acc_q[63:32], acc_q[31]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift - {1'b0, opnd_q};
        div_rem   = div_ge ? div_diff[31:0] : div_shift[31:0];
        div_next  = {div_rem, acc_q[30:0], div_ge};

        step_next = is_div_q ? div_next : mul_next;

        mul_res   = neg_lo_q ? neg64(step_next) : step_next;
        if (is_div_q) begin
            fin_hi = neg_hi_q ? neg32(step_next[63:32]) : step_next[63:32];
            fin_lo = neg_lo_q ? neg32(step_next[31:0])  : step_next[31:0];
        end else begin
            fin_hi = mul_res[63:32];
            fin_lo = mul_res[31:0];
        end
    end

    // Next-state, result and datapath update logic
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        hilo_we_d = 1'b0;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        is_div_d  = op_div;
                        neg_lo_d  = a_neg ^ b_neg;
                        neg_hi_d  = a_neg;
                        opnd_d    = op_div ? b_mag : a_mag;
                        acc_d     = {32'd0, (op_div ? a_mag : b_mag)};
                        counter_d = 5'd0;
                        if (op_div && (ex_srcRight == 32'd0)) begin
                            state_d   = S_DONE;
                            hi_d      = ex_srcLeft;
                            lo_d      = 32'hFFFF_FFFF;
                            hilo_we_d = 1'b1;
                        end else begin
                            state_d = S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    acc_d     = step_next;
                    counter_d = counter_q + 5'd1;
                    if (counter_q == 5'd31) begin
                        state_d   = S_DONE;
                        counter_d = 5'd0;
                        hi_d      = fin_hi;
                        lo_d      = fin_lo;
                        hilo_we_d = 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d == S_BUSY);
    end

    // Control and result registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            counter_q <= 5'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            hilo_we_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            hilo_we_q <= hilo_we_d;
            busy_q    <= busy_d;
        end
    end

    // Datapath registers; always reloaded on start, so no reset needed
    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        opnd_q   <= opnd_d;
        is_div_q <= is_div_d;
        neg_lo_q <= neg_lo_d;
        neg_hi_q <= neg_hi_d;
    end

    assign stall   = start || ((state_q == S_BUSY) && !flush);
    assign busy    = busy_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign hilo_we = hilo_we_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed corner cases plus random operations
// compared against a plain-arithmetic reference model.

module tb_ex_muldiv;

    localparam logic [2:0] SEL_ALU    = 3'b000;
    localparam logic [2:0] SEL_MULDIV = 3'b110;
    localparam logic [7:0] OP_MULT    = 8'h18;
    localparam logic [7:0] OP_MULTU   = 8'h19;
    localparam logic [7:0] OP_DIV     = 8'h1A;
    localparam logic [7:0] OP_DIVU    = 8'h1B;

    logic        clk;
    logic        rst;
    logic [2:0]  ex_alusel;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_srcLeft;
    logic [31:0] ex_srcRight;
    logic        flush;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        hilo_we;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_hi  = 32'd0;
    logic [31:0] exp_lo  = 32'd0;

    ex_muldiv dut (
        .clk         (clk),
        .rst         (rst),
        .ex_alusel   (ex_alusel),
        .ex_aluop    (ex_aluop),
        .ex_srcLeft  (ex_srcLeft),
        .ex_srcRight (ex_srcRight),
        .flush       (flush),
        .stall       (stall),
        .busy        (busy),
        .hi          (hi),
        .lo          (lo),
        .hilo_we     (hilo_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result {hi, lo} computed with ordinary 64-bit arithmetic
    function automatic logic [63:0] ref_model(input logic [7:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        res = 64'd0;
        case (op)
            OP_MULT:  res = 64'(sa * sb);
            OP_MULTU: res = ua * ub;
            OP_DIV: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else            res = {a % b, a / b};
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Present one op in EX (called at posedge+1) and follow it to its DONE cycle
    task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [63:0] r;
        int          stalls;
        int          exp_st;
        bit          done;
        r      = ref_model(op, a, b);
        exp_st = ((op == OP_DIV || op == OP_DIVU) && b == 32'd0) ? 1 : 33;
        ex_alusel   = SEL_MULDIV;
        ex_aluop    = op;
        ex_srcLeft  = a;
        ex_srcRight = b;
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk({tag, "_c0_we"}, hilo_we, 1'b0);
                chk({tag, "_c0_hold"}, {hi, lo}, {exp_hi, exp_lo});
            end
            if (i == 1 && exp_st == 33) chk({tag, "_busy"}, busy, 1'b1);
            if (hilo_we) begin
                done = 1'b1;
                break;
            end
            if (!stall) break;
            stalls++;
            @(posedge clk);
            #1;
        end
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_stalls"}, stalls, exp_st);
        chk({tag, "_done_stall"}, stall, 1'b0);
        chk({tag, "_hi"}, hi, r[63:32]);
        chk({tag, "_lo"}, lo, r[31:0]);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        @(posedge clk);
        #1;
        ex_alusel = SEL_ALU;
        ex_aluop  = 8'h00;
    endtask

    // Non-MULDIV cycles: the unit must stay quiet and hold HI/LO
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            ex_alusel   = SEL_ALU;
            ex_aluop    = 8'($urandom);
            ex_srcLeft  = $urandom;
            ex_srcRight = $urandom;
            @(negedge clk);
            chk("idle_stall", stall, 1'b0);
            chk("idle_we", hilo_we, 1'b0);
            chk("idle_busy", busy, 1'b0);
            chk("idle_hilo", {hi, lo}, {exp_hi, exp_lo});
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0]  op;
        logic [31:0] a, b;

        rst         = 1'b1;
        flush       = 1'b0;
        ex_alusel   = SEL_ALU;
        ex_aluop    = 8'h00;
        ex_srcLeft  = 32'd0;
        ex_srcRight = 32'd0;
        #2 rst = 1'b0;
        #1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_we", hilo_we, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_stall", stall, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        idle(2);

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max_hi_const", exp_hi, 32'hFFFF_FFFE);
        idle(2);
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3);
        chk("mult_neg_lo_const", exp_lo, 32'hFFFF_FFFA);
        idle(1);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_m7_2_lo_const", exp_lo, 32'hFFFF_FFFD);
        run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_min_m1_lo_const", exp_lo, 32'h8000_0000);
        run_op("mult_min_min", OP_MULT, 32'h8000_0000, 32'h8000_0000);
        chk("mult_min_min_hi_const", exp_hi, 32'h4000_0000);
        run_op("mult_min_min_again", OP_MULT, 32'h8000_0000, 32'h8000_0000);
        idle(1);
        run_op("divu_by0", OP_DIVU, 32'd100, 32'd0);
        idle(1);
        run_op("div_by0", OP_DIV, 32'hFFFF_FF00, 32'd0);
        idle(1);

        // Unknown aluop inside the MULDIV group is a no-op
        ex_alusel = SEL_MULDIV;
        ex_aluop  = 8'h00;
        @(negedge clk);
        chk("badop_stall", stall, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("badop_busy", busy, 1'b0);
        chk("badop_we", hilo_we, 1'b0);
        @(posedge clk);
        #1;
        idle(1);

        // flush together with a would-be start: flush wins
        ex_alusel   = SEL_MULDIV;
        ex_aluop    = OP_MULTU;
        ex_srcLeft  = 32'd9;
        ex_srcRight = 32'd9;
        flush       = 1'b1;
        @(negedge clk);
        chk("flush_start_stall", stall, 1'b0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        idle(3);

        // flush during BUSY cycle 10
        ex_alusel   = SEL_MULDIV;
        ex_aluop    = OP_MULTU;
        ex_srcLeft  = 32'hFFFF_1234;
        ex_srcRight = 32'h0000_ABCD;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_busy_stall", stall, 1'b0);
        chk("flush_busy_reg", busy, 1'b1);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        ex_alusel = SEL_ALU;
        @(negedge clk);
        chk("flush_after_busy", busy, 1'b0);
        chk("flush_after_we", hilo_we, 1'b0);
        chk("flush_after_hilo", {hi, lo}, {exp_hi, exp_lo});
        @(posedge clk);
        #1;
        idle(35);
        run_op("multu_3x5", OP_MULTU, 32'd3, 32'd5);
        chk("multu_3x5_lo_const", exp_lo, 32'd15);

        // Random operations, some back-to-back, some separated by bubbles
        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 3))
                0:       op = OP_MULT;
                1:       op = OP_MULTU;
                2:       op = OP_DIV;
                default: op = OP_DIVU;
            endcase
            a = pick_operand();
            b = pick_operand();
            run_op("rand", op, a, b);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        // Asynchronous reset in BUSY cycle 5, between clock edges
        ex_alusel   = SEL_MULDIV;
        ex_aluop    = OP_MULTU;
        ex_srcLeft  = 32'hFFFF_FFFF;
        ex_srcRight = 32'd7;
        repeat (6) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        chk("arst_we", hilo_we, 1'b0);
        chk("arst_stall", stall, 1'b0);
        chk("arst_busy", busy, 1'b0);
        exp_hi    = 32'd0;
        exp_lo    = 32'd0;
        ex_alusel = SEL_ALU;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_op("multu_2x2", OP_MULTU, 32'd2, 32'd2);
        chk("multu_2x2_lo_const", exp_lo, 32'd4);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
